// File: rtl/mips_mem_pkg.sv
// Shared control-bit indices and FSM encoding for the MEM-stage bus interface.
package mips_mem_pkg;

    localparam int unsigned CTL_MEMREAD  = 0;
    localparam int unsigned CTL_MEMWRITE = 1;
    localparam int unsigned CTL_MEMTOREG = 2;
    localparam int unsigned CTL_REGWRITE = 3;
    localparam int unsigned CTL_SPARE    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GRANT  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_bus_if_if.sv
// Data-memory bus shared between the MEM stage (master) and memory/DMA side (slave).
interface mem_stage_bus_if_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              hold_req;
    logic              hlda;
    logic              bus_err;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr, mem_oe, hlda, bus_err,
        input  mem_rdata, mem_ready, hold_req
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_oe, hlda, bus_err,
        output mem_rdata, mem_ready, hold_req
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state counter with terminal-count flag; only exists when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flags the wait cycle that brings the count up to MAX_WAIT.
    assign tc_o = count_en_i && (cnt_q == CntW'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mem_stage_bus_if.sv
// MEM stage: turns the EX/MEM bundle into data-bus cycles, arbitrates with DMA via HRQ/HLDA,
// and registers MEM/WB. Define MEM_TIMEOUT_EN to abort accesses after MAX_WAIT wait states.
module mem_stage_bus_if
    import mips_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned PC_W     = 15,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        control_in,
    input  logic [DATA_W-1:0] alu_output_in,
    input  logic [DATA_W-1:0] mem_Write_Data_in,
    input  logic [4:0]        rd_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              stall,
    mem_stage_bus_if_if.master bus,
    output logic [1:0]        wb_control_out,
    output logic [DATA_W-1:0] wb_read_data_out,
    output logic [DATA_W-1:0] wb_alu_out,
    output logic [4:0]        wb_rd_out,
    output logic [PC_W-1:0]   wb_pc_out,
    output logic              wb_valid_out
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              hlda_q, hlda_d;
    logic              oe_q, oe_d;
    logic [1:0]        wb_ctl_q, wb_ctl_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [PC_W-1:0]   wb_pc_q, wb_pc_d;
    logic              wb_valid_q, wb_valid_d;

    logic              mem_op;
    logic              is_write;
    logic              access_start;
    logic              wait_cycle;
    logic              wait_abort;
    logic              wb_load;
    logic [DATA_W-1:0] wb_rdata_new;

    // Write wins when both MemRead and MemWrite are set.
    assign mem_op     = control_in[CTL_MEMREAD] | control_in[CTL_MEMWRITE];
    assign is_write   = control_in[CTL_MEMWRITE];
    assign wait_cycle = (state_q == ACCESS) && !bus.mem_ready;

`ifdef MEM_TIMEOUT_EN
    logic bus_err_q, bus_err_d;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (access_start),
        .count_en_i (wait_cycle),
        .tc_o       (wait_abort)
    );

    assign bus_err_d   = wait_abort;
    assign bus.bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end
`else
    logic unused_max_wait;
    logic unused_wait_cycle;

    assign wait_abort        = 1'b0;
    assign bus.bus_err       = 1'b0;
    assign unused_max_wait   = (MAX_WAIT != 0);
    assign unused_wait_cycle = wait_cycle;
`endif

    logic unused_spare;
    assign unused_spare = control_in[CTL_SPARE];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        hlda_d       = hlda_q;
        oe_d         = oe_q;
        stall        = 1'b0;
        wb_load      = 1'b0;
        access_start = 1'b0;
        wb_rdata_new = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.hold_req) begin
                    state_d = GRANT;
                    hlda_d  = 1'b1;
                    oe_d    = 1'b0;
                    stall   = mem_op;
                    wb_load = !mem_op;
                end else if (mem_op) begin
                    state_d      = ACCESS;
                    addr_d       = alu_output_in[ADDR_W-1:0];
                    wdata_d      = mem_Write_Data_in;
                    rd_d         = !is_write;
                    wr_d         = is_write;
                    stall        = 1'b1;
                    access_start = 1'b1;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    state_d      = IDLE;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    wb_load      = 1'b1;
                    wb_rdata_new = is_write ? '0 : bus.mem_rdata;
                end else if (wait_abort) begin
                    // Aborted access retires as a bubble so the pipeline can move on.
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    stall = 1'b1;
                end
            end
            GRANT: begin
                stall   = mem_op;
                wb_load = !mem_op;
                if (!bus.hold_req) begin
                    state_d = IDLE;
                    hlda_d  = 1'b0;
                    oe_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_ctl_d   = 2'b00;
        wb_rdata_d = wb_rdata_q;
        wb_alu_d   = wb_alu_q;
        wb_rd_d    = wb_rd_q;
        wb_pc_d    = wb_pc_q;
        if (wb_load) begin
            wb_valid_d = 1'b1;
            wb_ctl_d   = {control_in[CTL_REGWRITE], control_in[CTL_MEMTOREG]};
            wb_rdata_d = wb_rdata_new;
            wb_alu_d   = alu_output_in;
            wb_rd_d    = rd_in;
            wb_pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            hlda_q     <= 1'b0;
            oe_q       <= 1'b1;
            wb_ctl_q   <= 2'b00;
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
            wb_pc_q    <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            hlda_q     <= hlda_d;
            oe_q       <= oe_d;
            wb_ctl_q   <= wb_ctl_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
            wb_pc_q    <= wb_pc_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_rd       = rd_q;
    assign bus.mem_wr       = wr_q;
    assign bus.mem_oe       = oe_q;
    assign bus.hlda         = hlda_q;
    assign wb_control_out   = wb_ctl_q;
    assign wb_read_data_out = wb_rdata_q;
    assign wb_alu_out       = wb_alu_q;
    assign wb_rd_out        = wb_rd_q;
    assign wb_pc_out        = wb_pc_q;
    assign wb_valid_out     = wb_valid_q;

endmodule

// File: tb/tb_mem_stage_bus_if.sv
// Self-checking bench for mem_stage_bus_if: directed scenarios plus a randomized instruction stream.
module tb_mem_stage_bus_if;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned PC_W     = 15;
    localparam int unsigned MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        control_in;
    logic [DATA_W-1:0] alu_output_in;
    logic [DATA_W-1:0] mem_Write_Data_in;
    logic [4:0]        rd_in;
    logic [PC_W-1:0]   pc_in;
    logic              stall;
    logic [1:0]        wb_control_out;
    logic [DATA_W-1:0] wb_read_data_out;
    logic [DATA_W-1:0] wb_alu_out;
    logic [4:0]        wb_rd_out;
    logic [PC_W-1:0]   wb_pc_out;
    logic              wb_valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_bus_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_stage_bus_if #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PC_W     (PC_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .control_in        (control_in),
        .alu_output_in     (alu_output_in),
        .mem_Write_Data_in (mem_Write_Data_in),
        .rd_in             (rd_in),
        .pc_in             (pc_in),
        .stall             (stall),
        .bus               (bus),
        .wb_control_out    (wb_control_out),
        .wb_read_data_out  (wb_read_data_out),
        .wb_alu_out        (wb_alu_out),
        .wb_rd_out         (wb_rd_out),
        .wb_pc_out         (wb_pc_out),
        .wb_valid_out      (wb_valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] rd_pattern(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] ctl, input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [14:0] pc);
        control_in        = ctl;
        alu_output_in     = alu;
        mem_Write_Data_in = wd;
        rd_in             = rd;
        pc_in             = pc;
    endtask

    // Drives one instruction until it retires, acting as a memory with `waits` wait states.
    task automatic run_instr(input logic [4:0] ctl, input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [14:0] pc, input int waits,
                             output int stall_cyc, output int strobe_cyc, output int strobe_bad,
                             output int bubble_bad, output bit expired);
        logic st;
        set_instr(ctl, alu, wd, rd, pc);
        stall_cyc  = 0;
        strobe_cyc = 0;
        strobe_bad = 0;
        bubble_bad = 0;
        expired    = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (bus.mem_rd || bus.mem_wr) begin
                strobe_cyc++;
                if (bus.mem_addr !== alu[15:0] || bus.mem_wr !== ctl[1] ||
                    bus.mem_rd !== (ctl[0] & ~ctl[1]) || (ctl[1] && bus.mem_wdata !== wd))
                    strobe_bad++;
                bus.mem_ready = (strobe_cyc == waits + 1);
            end else begin
                bus.mem_ready = 1'b0;
            end
            bus.mem_rdata = rd_pattern(bus.mem_addr);
            @(negedge clk);
            st = stall;
            tick();
            if (!st) begin
                expired = 1'b0;
                break;
            end
            stall_cyc++;
            if (wb_valid_out !== 1'b0 || wb_control_out !== 2'b00) bubble_bad++;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(5'b00000, $urandom, $urandom, 5'd0, 15'd0);
        bus.hold_req  = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) tick();
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin n_fail++;
            $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus.mem_rd, bus.mem_wr); end
        n_checks++; if (bus.mem_oe !== 1'b1) begin n_fail++;
            $display("FAIL reset_oe: got %b want 1", bus.mem_oe); end
        n_checks++; if (bus.hlda !== 1'b0 || bus.bus_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_hlda_err: got %b %b want 0 0", bus.hlda, bus.bus_err); end
        n_checks++; if ({wb_valid_out, wb_control_out, wb_alu_out, wb_read_data_out} !== '0) begin
            n_fail++; $display("FAIL reset_wb: got v=%b c=%b alu=%h rd=%h want 0", wb_valid_out,
                               wb_control_out, wb_alu_out, wb_read_data_out); end
        n_checks++; if (stall !== 1'b0 || bus.mem_addr !== 16'h0) begin n_fail++;
            $display("FAIL reset_stall_addr: got %b %h want 0 0000", stall, bus.mem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        int sc, stc, sb, bb;
        bit ex;
        run_instr(5'b01000, 32'h0000_1234, 32'h0, 5'd7, 15'h0123, 0, sc, stc, sb, bb, ex);
        n_checks++; if (sc !== 0 || stc !== 0 || ex) begin n_fail++;
            $display("FAIL alu_stall: got stall=%0d strobe=%0d exp=%b want 0 0 0", sc, stc, ex); end
        n_checks++; if (wb_alu_out !== 32'h1234 || wb_control_out !== 2'b10 || wb_valid_out !== 1'b1)
            begin n_fail++; $display("FAIL alu_wb: got alu=%h c=%b v=%b want 1234 10 1",
                                     wb_alu_out, wb_control_out, wb_valid_out); end
        n_checks++; if (wb_rd_out !== 5'd7 || wb_pc_out !== 15'h0123 || wb_read_data_out !== 0) begin
            n_fail++; $display("FAIL alu_fields: got rd=%0d pc=%h data=%h want 7 0123 0",
                               wb_rd_out, wb_pc_out, wb_read_data_out); end
    endtask

    task automatic test_load();
        set_instr(5'b01101, 32'h0000_0040, 32'h0, 5'd3, 15'h0010);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1 || bus.mem_rd !== 1'b0) begin n_fail++;
            $display("FAIL load_issue: got stall=%b rd=%b want 1 0", stall, bus.mem_rd); end
        tick();
        n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0040) begin n_fail++;
            $display("FAIL load_strobe: got rd=%b addr=%h want 1 0040", bus.mem_rd, bus.mem_addr); end
        n_checks++; if (wb_valid_out !== 1'b0 || wb_alu_out !== 32'h1234) begin n_fail++;
            $display("FAIL load_bubble: got v=%b alu=%h want 0 1234", wb_valid_out, wb_alu_out); end
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++;
            $display("FAIL load_ready_stall: got %b want 0", stall); end
        tick();
        bus.mem_ready = 1'b0;
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (bus.mem_rd !== 1'b0 || wb_read_data_out !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL load_wb_data: got rd=%b data=%h want 0 deadbeef", bus.mem_rd,
                     wb_read_data_out); end
        n_checks++; if (wb_valid_out !== 1'b1 || wb_control_out !== 2'b11 || wb_alu_out !== 32'h40)
            begin n_fail++; $display("FAIL load_wb_ctl: got v=%b c=%b alu=%h want 1 11 40",
                                     wb_valid_out, wb_control_out, wb_alu_out); end
        tick();
    endtask

    task automatic test_store_wait();
        int sc, stc, sb, bb;
        bit ex;
        run_instr(5'b00010, 32'h0000_2468, 32'hA5A5_0F0F, 5'd0, 15'h0044, 3, sc, stc, sb, bb, ex);
        n_checks++; if (sc !== 4 || stc !== 4 || ex) begin n_fail++;
            $display("FAIL store_wait_len: got stall=%0d strobe=%0d exp=%b want 4 4 0", sc, stc, ex); end
        n_checks++; if (sb !== 0 || bb !== 0) begin n_fail++;
            $display("FAIL store_wait_stable: got strobe_bad=%0d bubble_bad=%0d want 0 0", sb, bb); end
        n_checks++; if (wb_valid_out !== 1'b1 || wb_read_data_out !== 0 || wb_pc_out !== 15'h0044)
            begin n_fail++; $display("FAIL store_wb: got v=%b data=%h pc=%h want 1 0 0044",
                                     wb_valid_out, wb_read_data_out, wb_pc_out); end
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++;
            $display("FAIL store_wr_drop: got %b want 0", bus.mem_wr); end
    endtask

    task automatic test_hold_during_access();
        int bad;
        bad = 0;
        set_instr(5'b01101, 32'h0000_0200, 32'h0, 5'd9, 15'h0200);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        tick();
        bus.hold_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.mem_ready = (k == 2);
            bus.mem_rdata = 32'hCAFE_0001;
            if (bus.hlda !== 1'b0 || bus.mem_oe !== 1'b1 || bus.mem_rd !== 1'b1) bad++;
            tick();
        end
        bus.mem_ready = 1'b0;
        n_checks++; if (bad !== 0 || bus.hlda !== 1'b0) begin n_fail++;
            $display("FAIL hold_in_access: got bad=%0d hlda=%b want 0 0", bad, bus.hlda); end
        n_checks++; if (wb_read_data_out !== 32'hCAFE_0001 || wb_valid_out !== 1'b1) begin n_fail++;
            $display("FAIL hold_access_wb: got %h v=%b want cafe0001 1", wb_read_data_out,
                     wb_valid_out); end
        set_instr(5'b01101, 32'h0000_0080, 32'h0, 5'd10, 15'h0210);
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++;
            $display("FAIL hold_idle_stall: got %b want 1", stall); end
        tick();
        n_checks++; if (bus.hlda !== 1'b1 || bus.mem_oe !== 1'b0 || bus.mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL grant_entry: got hlda=%b oe=%b rd=%b want 1 0 0", bus.hlda,
                               bus.mem_oe, bus.mem_rd); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (stall !== 1'b1) bad++;
            tick();
            if (wb_valid_out !== 1'b0 || bus.mem_rd !== 1'b0 || bus.hlda !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++;
            $display("FAIL grant_hold: got %0d bad cycles want 0", bad); end
        bus.hold_req = 1'b0;
        @(negedge clk);
        bad = (stall !== 1'b1) ? 1 : 0;
        tick();
        n_checks++; if (bad !== 0 || bus.hlda !== 1'b0 || bus.mem_oe !== 1'b1 || bus.mem_rd !== 1'b0)
            begin n_fail++; $display("FAIL grant_exit: got bad=%0d hlda=%b oe=%b rd=%b want 0 0 1 0",
                                     bad, bus.hlda, bus.mem_oe, bus.mem_rd); end
        @(negedge clk);
        tick();
        n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0080) begin n_fail++;
            $display("FAIL grant_load_issue: got rd=%b addr=%h want 1 0080", bus.mem_rd,
                     bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus.mem_ready = 1'b0;
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (wb_read_data_out !== 32'h0BAD_F00D || wb_rd_out !== 5'd10) begin n_fail++;
            $display("FAIL grant_load_wb: got %h rd=%0d want 0badf00d 10", wb_read_data_out,
                     wb_rd_out); end
        tick();
    endtask

    task automatic test_hold_and_load();
        int bad;
        set_instr(5'b01101, 32'h0000_0300, 32'h0, 5'd11, 15'h0300);
        bus.hold_req = 1'b1;
        @(negedge clk);
        bad = (stall !== 1'b1) ? 1 : 0;
        tick();
        n_checks++; if (bad !== 0 || bus.hlda !== 1'b1 || bus.mem_rd !== 1'b0) begin n_fail++;
            $display("FAIL hold_first: got bad=%0d hlda=%b rd=%b want 0 1 0", bad, bus.hlda,
                     bus.mem_rd); end
        tick();
        bus.hold_req = 1'b0;
        tick();
        n_checks++; if (bus.hlda !== 1'b0 || bus.mem_rd !== 1'b0) begin n_fail++;
            $display("FAIL hold_release: got hlda=%b rd=%b want 0 0", bus.hlda, bus.mem_rd); end
        tick();
        n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0300) begin n_fail++;
            $display("FAIL hold_then_load: got rd=%b addr=%h want 1 0300", bus.mem_rd,
                     bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1357_9BDF;
        tick();
        bus.mem_ready = 1'b0;
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (wb_read_data_out !== 32'h1357_9BDF || wb_valid_out !== 1'b1) begin n_fail++;
            $display("FAIL hold_load_wb: got %h v=%b want 13579bdf 1", wb_read_data_out,
                     wb_valid_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_instr(5'b01101, 32'h0000_0400, 32'h0, 5'd12, 15'h0400);
        bus.mem_ready = 1'b0;
        tick();
        n_checks++; if (bus.mem_rd !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_pre: got rd=%b want 1", bus.mem_rd); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (bus.mem_rd !== 1'b0 || wb_valid_out !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_access: got rd=%b v=%b want 0 0", bus.mem_rd, wb_valid_out); end
        bus.hold_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (bus.hlda !== 1'b0 || bus.mem_oe !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_grant: got hlda=%b oe=%b want 0 1", bus.hlda, bus.mem_oe); end
        rst = 1'b0;
        bus.hold_req = 1'b0;
        tick();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_wait_limit();
        int bad;
        bad = 0;
        set_instr(5'b01101, 32'h0000_0500, 32'h0, 5'd13, 15'h0500);
        bus.mem_ready = 1'b0;
        tick();
        for (int k = 1; k <= int'(MAX_WAIT); k++) begin
            @(negedge clk);
            if (stall !== ((k < int'(MAX_WAIT)) ? 1'b1 : 1'b0) || bus.bus_err !== 1'b0) bad++;
            tick();
        end
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (bad !== 0) begin n_fail++;
            $display("FAIL timeout_waits: got %0d bad cycles want 0", bad); end
        n_checks++; if (bus.bus_err !== 1'b1 || bus.mem_rd !== 1'b0 || wb_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL timeout_abort: got err=%b rd=%b v=%b want 1 0 0", bus.bus_err,
                               bus.mem_rd, wb_valid_out); end
        tick();
        n_checks++; if (bus.bus_err !== 1'b0 || wb_valid_out !== 1'b1) begin n_fail++;
            $display("FAIL timeout_pulse: got err=%b v=%b want 0 1", bus.bus_err, wb_valid_out); end
    endtask
`else
    task automatic test_wait_limit();
        int bad;
        bad = 0;
        set_instr(5'b01101, 32'h0000_0500, 32'h0, 5'd13, 15'h0500);
        bus.mem_ready = 1'b0;
        tick();
        repeat (20) begin
            @(negedge clk);
            if (stall !== 1'b1 || bus.bus_err !== 1'b0 || bus.mem_rd !== 1'b1) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) begin n_fail++;
            $display("FAIL long_wait: got %0d bad cycles want 0", bad); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h2468_ACE0;
        tick();
        bus.mem_ready = 1'b0;
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        n_checks++; if (wb_valid_out !== 1'b1 || wb_read_data_out !== 32'h2468_ACE0) begin n_fail++;
            $display("FAIL long_wait_wb: got v=%b data=%h want 1 2468ace0", wb_valid_out,
                     wb_read_data_out); end
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        int          sc, stc, sb, bb, waits, kind;
        bit          ex;
        logic [4:0]  ctl, rd;
        logic [31:0] alu, wd, exp_data;
        logic [14:0] pc;
        bit          is_mem;
        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 3);
            waits = $urandom_range(0, 4);
            alu   = $urandom;
            wd    = $urandom;
            rd    = 5'($urandom_range(0, 31));
            pc    = 15'($urandom_range(0, 32767));
            unique case (kind)
                0:       ctl = {3'($urandom_range(0, 7)), 2'b00};
                1:       ctl = {3'($urandom_range(0, 7)), 2'b01};
                2:       ctl = {3'($urandom_range(0, 7)), 2'b10};
                default: ctl = {3'($urandom_range(0, 7)), 2'b11};
            endcase
            is_mem   = (kind != 0);
            exp_data = (kind == 1) ? rd_pattern(alu[15:0]) : 32'h0;
            run_instr(ctl, alu, wd, rd, pc, waits, sc, stc, sb, bb, ex);
            n_checks++; if (ex || sc !== (is_mem ? waits + 1 : 0)) begin n_fail++;
                $display("FAIL rnd_stall[%0d]: got %0d exp=%b want %0d", i, sc, ex,
                         is_mem ? waits + 1 : 0); end
            n_checks++; if (stc !== (is_mem ? waits + 1 : 0) || sb !== 0 || bb !== 0) begin n_fail++;
                $display("FAIL rnd_bus[%0d]: got strobe=%0d bad=%0d bub=%0d want %0d 0 0", i, stc,
                         sb, bb, is_mem ? waits + 1 : 0); end
            n_checks++; if (wb_valid_out !== 1'b1 || wb_control_out !== {ctl[3], ctl[2]}) begin
                n_fail++; $display("FAIL rnd_ctl[%0d]: got v=%b c=%b want 1 %b", i, wb_valid_out,
                                   wb_control_out, {ctl[3], ctl[2]}); end
            n_checks++; if (wb_read_data_out !== exp_data || wb_alu_out !== alu) begin n_fail++;
                $display("FAIL rnd_data[%0d]: got data=%h alu=%h want %h %h", i, wb_read_data_out,
                         wb_alu_out, exp_data, alu); end
            n_checks++; if (wb_rd_out !== rd || wb_pc_out !== pc) begin n_fail++;
                $display("FAIL rnd_tag[%0d]: got rd=%0d pc=%h want %0d %h", i, wb_rd_out, wb_pc_out,
                         rd, pc); end
        end
        set_instr(5'b00000, 32'h0, 32'h0, 5'd0, 15'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_wait();
        test_hold_during_access();
        test_hold_and_load();
        test_wait_limit();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_bus_if.md
Name: mem_stage_bus_if

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched control/ALU/write-data bundle into data-memory bus cycles and registers the result into MEM/WB.
- Shares the memory bus with the 8237 DMA through a HRQ/HLDA hold handshake.
- Stalls the upstream pipeline while an access waits or while the DMA owns the bus.

Parameters:
- DATA_W, 32, width of ALU result, store data and read data.
- ADDR_W, 16, memory address width; taken as alu_output_in[ADDR_W-1:0].
- PC_W, 15, width of the pc field carried through.
- MAX_WAIT, 15, wait-state cycles tolerated before timeout (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- control_in  in  5  EX/MEM control: [0] MemRead, [1] MemWrite, [2] MemToReg, [3] RegWrite, [4] pass-through spare.
- alu_output_in  in  DATA_W  address or ALU result.
- mem_Write_Data_in  in  DATA_W  store data.
- rd_in  in  5  destination register.
- pc_in  in  PC_W  instruction pc.
- stall  out  1  combinational; 1 = upstream holds the EX/MEM contents.
- mem_addr  out  ADDR_W  registered bus address.
- mem_wdata  out  DATA_W  registered store data.
- mem_rd, mem_wr  out  1 each  registered bus strobes.
- mem_oe  out  1  1 = this block drives the bus; 0 while the DMA owns it.
- mem_rdata  in  DATA_W  read data.
- mem_ready  in  1  access completes this cycle.
- hold_req  in  1  HRQ from the DMA.
- hlda  out  1  registered hold acknowledge.
- wb_control_out  out  2  {RegWrite, MemToReg} to MEM/WB.
- wb_read_data_out  out  DATA_W  load data.
- wb_alu_out  out  DATA_W  ALU result.
- wb_rd_out  out  5  destination register.
- wb_pc_out  out  PC_W  instruction pc.
- wb_valid_out  out  1  0 = bubble.
- bus_err  out  1  timeout pulse (feature only).

Behaviour:
- Reset: state IDLE; every output 0, except mem_oe=1.
- A memory op is present when control_in[0] or control_in[1] is set. If both are set, the op is a write and the read bit is ignored.
- Upstream must keep all *_in signals stable while stall=1.
- FSM states:
  - IDLE, CPU owns the bus with no access.
  - ACCESS, strobe asserted, waiting for mem_ready.
  - GRANT, DMA owns the bus.
- IDLE transitions:
  - hold_req=1 → GRANT. Takes priority over a pending memory op; hlda=1 and mem_oe=0 from the next cycle.
  - else memory op present → ACCESS. mem_addr, mem_wdata and the relevant strobe are registered on this edge; stall=1.
  - else no memory op: MEM/WB loads the bundle on this edge (1-cycle latency), wb_valid_out=1, stall=0.
- ACCESS behaviour:
  - hold_req is ignored until the access completes.
  - mem_ready=0: stall=1; strobes and address hold.
  - mem_ready=1: stall=0; MEM/WB loads the bundle with wb_read_data_out=mem_rdata (loads) or 0 (stores); strobes drop next cycle; → IDLE.
  - Minimum load/store latency is 2 cycles.
- GRANT behaviour:
  - stall=1 whenever an EX/MEM op is present; mem_rd/mem_wr=0; MEM/WB receives bubbles.
  - hold_req=0 → IDLE; hlda and mem_oe return to 0 and 1 on the same edge.
- A stalled cycle writes a bubble: wb_valid_out=0, wb_control_out=0, other wb_* hold their previous values.
- Back-to-back memory ops: IDLE→ACCESS→IDLE per op (one idle cycle between accesses).
- Reset mid-ACCESS or mid-GRANT: strobes and hlda drop on the reset edge; no MEM/WB write.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a wait counter clears on entry to ACCESS and counts every mem_ready=0 cycle. When it reaches MAX_WAIT, the access aborts:
  - strobes drop, FSM → IDLE;
  - bus_err pulses for 1 cycle;
  - MEM/WB gets wb_valid_out=0;
  - stall=0 that cycle, so the instruction retires as a bubble.
- Undefined: no counter, infinite wait, bus_err tied 0.

Decomposition:
- Shared package mips_mem_pkg holds the control-bit index constants (CTL_MEMREAD=0 … CTL_SPARE=4) and the state enum {IDLE, ACCESS, GRANT}.
- One natural sub-module, mem_wait_timer: counter plus terminal-count flag, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- ALU op, control_in=5'b01000, alu=32'h1234 → 1 cycle later wb_alu_out=32'h1234, wb_control_out=2'b10, wb_valid_out=1, stall never asserted.
- Load, addr 16'h0040, mem_ready tied 1, mem_rdata=32'hDEADBEEF → mem_rd high 1 cycle, stall high 1 cycle, wb_read_data_out=32'hDEADBEEF 2 cycles after issue.
- Store with mem_ready low 3 cycles → mem_wr and address stable 4 cycles, stall high 4 cycles, single valid MEM/WB write.
- hold_req rises during ACCESS → hlda stays 0 until completion, then 1 the cycle after return to IDLE; mem_oe=0; a load arriving during GRANT stalls until hold_req falls, then issues.
- hold_req and a load both present in IDLE → GRANT taken first, load issued after hlda drops.
- MEM_TIMEOUT_EN with MAX_WAIT=15 and mem_ready stuck 0 → bus_err pulses on wait cycle 15, wb_valid_out=0, FSM back in IDLE.
